// File: rtl/lsu_pkg.sv
// Shared types, constants and helpers for the load/store stage.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [63:0] CAUSE_LOAD_MISALIGN  = 64'd4;
  localparam logic [63:0] CAUSE_LOAD_FAULT     = 64'd5;
  localparam logic [63:0] CAUSE_STORE_MISALIGN = 64'd6;
  localparam logic [63:0] CAUSE_STORE_FAULT    = 64'd7;

  // Contents of the LS/WB pipeline register.
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] next_pc;
    logic [31:0] inst;
    logic        trap_valid;
    logic        mret_valid;
    logic        sret_valid;
    logic [63:0] trap_cause;
    logic [63:0] trap_tval;
    logic        csr_wen;
    logic        csr_ren;
    logic [11:0] csr_addr;
    logic [4:0]  rd;
    logic        dest_wen;
    logic [63:0] data;
  } wb_t;

  // Byte-lane mask of an access of the given size, before offset shift.
  function automatic logic [7:0] size_mask(input size_e size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [2:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [63:0] store_lanes(input size_e size, input logic [63:0] d);
    case (size)
      SZ_B:    return {8{d[7:0]}};
      SZ_H:    return {4{d[15:0]}};
      SZ_W:    return {2{d[31:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts a doubleword of read data down to the accessed bytes and extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [63:0] data_o
);

  logic [63:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  // Sign- or zero-extend the low bytes according to the access size.
  always_comb begin
    data_o = shifted;
    case (size_e'(size_i))
      SZ_B: data_o = unsigned_i ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SZ_H: data_o = unsigned_i ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W: data_o = unsigned_i ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: one outstanding data-memory access, results to LS/WB.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_LS_reg_execute_valid,
  output logic            LS_EX_execute_ready,
  input  logic [XLEN-1:0] EX_LS_reg_PC,
  input  logic [XLEN-1:0] EX_LS_reg_next_PC,
  input  logic [31:0]     EX_LS_reg_inst,
  input  logic            EX_LS_reg_trap_valid,
  input  logic            EX_LS_reg_mret_valid,
  input  logic            EX_LS_reg_sret_valid,
  input  logic [XLEN-1:0] EX_LS_reg_trap_cause,
  input  logic [XLEN-1:0] EX_LS_reg_trap_tval,
  input  logic            EX_LS_reg_csr_wen,
  input  logic            EX_LS_reg_csr_ren,
  input  logic [11:0]     EX_LS_reg_csr_addr,
  input  logic [4:0]      EX_LS_reg_rd,
  input  logic            EX_LS_reg_dest_wen,
  input  logic [XLEN-1:0] EX_LS_reg_data,
  input  logic [XLEN-1:0] EX_LS_reg_store_data,
  input  logic            EX_LS_reg_load,
  input  logic            EX_LS_reg_store,
  input  logic [1:0]      EX_LS_reg_size,
  input  logic            EX_LS_reg_unsigned,
  output logic            LS_MEM_req_valid,
  input  logic            MEM_LS_req_ready,
  output logic [XLEN-1:0] LS_MEM_addr,
  output logic            LS_MEM_wen,
  output logic [XLEN-1:0] LS_MEM_wdata,
  output logic [7:0]      LS_MEM_wstrb,
  input  logic            MEM_LS_resp_valid,
  input  logic [XLEN-1:0] MEM_LS_rdata,
  input  logic            MEM_LS_resp_err,
  input  logic            WB_LS_ls_ready,
  input  logic            WB_LS_flush_flag,
  output logic            LS_WB_reg_ls_valid,
  output logic [XLEN-1:0] LS_WB_reg_PC,
  output logic [XLEN-1:0] LS_WB_reg_next_PC,
  output logic [31:0]     LS_WB_reg_inst,
  output logic            LS_WB_reg_trap_valid,
  output logic            LS_WB_reg_mret_valid,
  output logic            LS_WB_reg_sret_valid,
  output logic [XLEN-1:0] LS_WB_reg_trap_cause,
  output logic [XLEN-1:0] LS_WB_reg_trap_tval,
  output logic            LS_WB_reg_csr_wen,
  output logic            LS_WB_reg_csr_ren,
  output logic [11:0]     LS_WB_reg_csr_addr,
  output logic [4:0]      LS_WB_reg_rd,
  output logic            LS_WB_reg_dest_wen,
  output logic [XLEN-1:0] LS_WB_reg_data
);

  state_e      state_q, state_d;
  logic        ls_valid_q, ls_valid_d;
  wb_t         wb_q, wb_d;
  wb_t         pend_q, pend_d;
  wb_t         entry;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        store_q, store_d;
  logic        accept;
  logic [63:0] load_data;

  assign LS_EX_execute_ready = (state_q == ST_IDLE) & (~ls_valid_q | WB_LS_ls_ready);
  assign accept = EX_LS_reg_execute_valid & LS_EX_execute_ready & ~WB_LS_flush_flag;

  assign LS_MEM_req_valid = (state_q == ST_REQ);
  assign LS_MEM_addr      = {addr_q[63:3], 3'b000};
  assign LS_MEM_wen       = store_q;
  assign LS_MEM_wdata     = wdata_q;
  assign LS_MEM_wstrb     = wstrb_q;

  lsu_load_align u_align (
    .rdata_i    (MEM_LS_rdata),
    .offset_i   (addr_q[2:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  // Pack the incoming instruction into LS/WB form; stores never write rd.
  always_comb begin
    entry            = '0;
    entry.pc         = EX_LS_reg_PC;
    entry.next_pc    = EX_LS_reg_next_PC;
    entry.inst       = EX_LS_reg_inst;
    entry.trap_valid = EX_LS_reg_trap_valid;
    entry.mret_valid = EX_LS_reg_mret_valid;
    entry.sret_valid = EX_LS_reg_sret_valid;
    entry.trap_cause = EX_LS_reg_trap_cause;
    entry.trap_tval  = EX_LS_reg_trap_tval;
    entry.csr_wen    = EX_LS_reg_csr_wen;
    entry.csr_ren    = EX_LS_reg_csr_ren;
    entry.csr_addr   = EX_LS_reg_csr_addr;
    entry.rd         = EX_LS_reg_rd;
    entry.dest_wen   = EX_LS_reg_dest_wen & ~EX_LS_reg_store;
    entry.data       = EX_LS_reg_data;
  end

  // Next-state, access latch and output-register update.
  always_comb begin
    state_d    = state_q;
    ls_valid_d = ls_valid_q;
    wb_d       = wb_q;
    pend_d     = pend_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    size_d     = size_q;
    uns_d      = uns_q;
    store_d    = store_q;

    if (ls_valid_q && WB_LS_ls_ready) ls_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!(EX_LS_reg_load || EX_LS_reg_store) || EX_LS_reg_trap_valid) begin
            wb_d       = entry;
            ls_valid_d = 1'b1;
          end else if (is_misaligned(size_e'(EX_LS_reg_size), EX_LS_reg_data[2:0])) begin
            wb_d            = entry;
            wb_d.trap_valid = 1'b1;
            wb_d.trap_cause = EX_LS_reg_load ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
            wb_d.trap_tval  = EX_LS_reg_data;
            wb_d.dest_wen   = 1'b0;
            ls_valid_d      = 1'b1;
          end else begin
            pend_d  = entry;
            addr_d  = EX_LS_reg_data;
            size_d  = EX_LS_reg_size;
            uns_d   = EX_LS_reg_unsigned;
            store_d = EX_LS_reg_store;
            wdata_d = store_lanes(size_e'(EX_LS_reg_size), EX_LS_reg_store_data);
            wstrb_d = size_mask(size_e'(EX_LS_reg_size)) << EX_LS_reg_data[2:0];
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (WB_LS_flush_flag) state_d = MEM_LS_req_ready ? ST_DRAIN : ST_IDLE;
        else if (MEM_LS_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A response coinciding with a flush is simply dropped; no drain needed.
        if (MEM_LS_resp_valid) begin
          state_d = ST_IDLE;
          if (!WB_LS_flush_flag) begin
            wb_d = pend_q;
            if (MEM_LS_resp_err) begin
              wb_d.trap_valid = 1'b1;
              wb_d.trap_cause = store_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
              wb_d.trap_tval  = addr_q;
              wb_d.dest_wen   = 1'b0;
            end else if (!store_q) begin
              wb_d.data = load_data;
            end
            ls_valid_d = 1'b1;
          end
        end else if (WB_LS_flush_flag) begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        if (MEM_LS_resp_valid) state_d = ST_IDLE;
      end
    endcase

    if (WB_LS_flush_flag) ls_valid_d = 1'b0;
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ls_valid_q   <= 1'b0;
      wb_q         <= '0;
      wb_q.pc      <= RESET_PC;
      wb_q.next_pc <= RESET_PC;
      pend_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      store_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ls_valid_q <= ls_valid_d;
      wb_q       <= wb_d;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      store_q    <= store_d;
    end
  end

  assign LS_WB_reg_ls_valid   = ls_valid_q;
  assign LS_WB_reg_PC         = wb_q.pc;
  assign LS_WB_reg_next_PC    = wb_q.next_pc;
  assign LS_WB_reg_inst       = wb_q.inst;
  assign LS_WB_reg_trap_valid = wb_q.trap_valid;
  assign LS_WB_reg_mret_valid = wb_q.mret_valid;
  assign LS_WB_reg_sret_valid = wb_q.sret_valid;
  assign LS_WB_reg_trap_cause = wb_q.trap_cause;
  assign LS_WB_reg_trap_tval  = wb_q.trap_tval;
  assign LS_WB_reg_csr_wen    = wb_q.csr_wen;
  assign LS_WB_reg_csr_ren    = wb_q.csr_ren;
  assign LS_WB_reg_csr_addr   = wb_q.csr_addr;
  assign LS_WB_reg_rd         = wb_q.rd;
  assign LS_WB_reg_dest_wen   = wb_q.dest_wen;
  assign LS_WB_reg_data       = wb_q.data;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage.
module tb_lsu_stage;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        EX_LS_reg_execute_valid = 1'b0;
  logic        LS_EX_execute_ready;
  logic [63:0] EX_LS_reg_PC = '0, EX_LS_reg_next_PC = '0;
  logic [31:0] EX_LS_reg_inst = '0;
  logic        EX_LS_reg_trap_valid = 1'b0, EX_LS_reg_mret_valid = 1'b0, EX_LS_reg_sret_valid = 1'b0;
  logic [63:0] EX_LS_reg_trap_cause = '0, EX_LS_reg_trap_tval = '0;
  logic        EX_LS_reg_csr_wen = 1'b0, EX_LS_reg_csr_ren = 1'b0;
  logic [11:0] EX_LS_reg_csr_addr = '0;
  logic [4:0]  EX_LS_reg_rd = '0;
  logic        EX_LS_reg_dest_wen = 1'b0;
  logic [63:0] EX_LS_reg_data = '0, EX_LS_reg_store_data = '0;
  logic        EX_LS_reg_load = 1'b0, EX_LS_reg_store = 1'b0;
  logic [1:0]  EX_LS_reg_size = '0;
  logic        EX_LS_reg_unsigned = 1'b0;
  logic        LS_MEM_req_valid;
  logic        MEM_LS_req_ready = 1'b0;
  logic [63:0] LS_MEM_addr;
  logic        LS_MEM_wen;
  logic [63:0] LS_MEM_wdata;
  logic [7:0]  LS_MEM_wstrb;
  logic        MEM_LS_resp_valid = 1'b0;
  logic [63:0] MEM_LS_rdata = '0;
  logic        MEM_LS_resp_err = 1'b0;
  logic        WB_LS_ls_ready = 1'b1;
  logic        WB_LS_flush_flag = 1'b0;
  logic        LS_WB_reg_ls_valid;
  logic [63:0] LS_WB_reg_PC, LS_WB_reg_next_PC;
  logic [31:0] LS_WB_reg_inst;
  logic        LS_WB_reg_trap_valid, LS_WB_reg_mret_valid, LS_WB_reg_sret_valid;
  logic [63:0] LS_WB_reg_trap_cause, LS_WB_reg_trap_tval;
  logic        LS_WB_reg_csr_wen, LS_WB_reg_csr_ren;
  logic [11:0] LS_WB_reg_csr_addr;
  logic [4:0]  LS_WB_reg_rd;
  logic        LS_WB_reg_dest_wen;
  logic [63:0] LS_WB_reg_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_stage #(.XLEN(64), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .EX_LS_reg_execute_valid(EX_LS_reg_execute_valid), .LS_EX_execute_ready(LS_EX_execute_ready),
    .EX_LS_reg_PC(EX_LS_reg_PC), .EX_LS_reg_next_PC(EX_LS_reg_next_PC), .EX_LS_reg_inst(EX_LS_reg_inst),
    .EX_LS_reg_trap_valid(EX_LS_reg_trap_valid), .EX_LS_reg_mret_valid(EX_LS_reg_mret_valid),
    .EX_LS_reg_sret_valid(EX_LS_reg_sret_valid), .EX_LS_reg_trap_cause(EX_LS_reg_trap_cause),
    .EX_LS_reg_trap_tval(EX_LS_reg_trap_tval), .EX_LS_reg_csr_wen(EX_LS_reg_csr_wen),
    .EX_LS_reg_csr_ren(EX_LS_reg_csr_ren), .EX_LS_reg_csr_addr(EX_LS_reg_csr_addr),
    .EX_LS_reg_rd(EX_LS_reg_rd), .EX_LS_reg_dest_wen(EX_LS_reg_dest_wen),
    .EX_LS_reg_data(EX_LS_reg_data), .EX_LS_reg_store_data(EX_LS_reg_store_data),
    .EX_LS_reg_load(EX_LS_reg_load), .EX_LS_reg_store(EX_LS_reg_store),
    .EX_LS_reg_size(EX_LS_reg_size), .EX_LS_reg_unsigned(EX_LS_reg_unsigned),
    .LS_MEM_req_valid(LS_MEM_req_valid), .MEM_LS_req_ready(MEM_LS_req_ready),
    .LS_MEM_addr(LS_MEM_addr), .LS_MEM_wen(LS_MEM_wen), .LS_MEM_wdata(LS_MEM_wdata),
    .LS_MEM_wstrb(LS_MEM_wstrb), .MEM_LS_resp_valid(MEM_LS_resp_valid),
    .MEM_LS_rdata(MEM_LS_rdata), .MEM_LS_resp_err(MEM_LS_resp_err),
    .WB_LS_ls_ready(WB_LS_ls_ready), .WB_LS_flush_flag(WB_LS_flush_flag),
    .LS_WB_reg_ls_valid(LS_WB_reg_ls_valid), .LS_WB_reg_PC(LS_WB_reg_PC),
    .LS_WB_reg_next_PC(LS_WB_reg_next_PC), .LS_WB_reg_inst(LS_WB_reg_inst),
    .LS_WB_reg_trap_valid(LS_WB_reg_trap_valid), .LS_WB_reg_mret_valid(LS_WB_reg_mret_valid),
    .LS_WB_reg_sret_valid(LS_WB_reg_sret_valid), .LS_WB_reg_trap_cause(LS_WB_reg_trap_cause),
    .LS_WB_reg_trap_tval(LS_WB_reg_trap_tval), .LS_WB_reg_csr_wen(LS_WB_reg_csr_wen),
    .LS_WB_reg_csr_ren(LS_WB_reg_csr_ren), .LS_WB_reg_csr_addr(LS_WB_reg_csr_addr),
    .LS_WB_reg_rd(LS_WB_reg_rd), .LS_WB_reg_dest_wen(LS_WB_reg_dest_wen),
    .LS_WB_reg_data(LS_WB_reg_data)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] sd, input logic trap);
    EX_LS_reg_PC         = 64'h0000_0000_0000_1000;
    EX_LS_reg_next_PC    = 64'h0000_0000_0000_1004;
    EX_LS_reg_inst       = 32'h0000_3003;
    EX_LS_reg_rd         = 5'd10;
    EX_LS_reg_dest_wen   = 1'b1;
    EX_LS_reg_data       = addr;
    EX_LS_reg_store_data = sd;
    EX_LS_reg_load       = ld;
    EX_LS_reg_store      = st;
    EX_LS_reg_size       = sz;
    EX_LS_reg_unsigned   = uns;
    EX_LS_reg_trap_valid = trap;
    EX_LS_reg_trap_cause = trap ? 64'd2 : 64'd0;
    EX_LS_reg_execute_valid = 1'b1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] sd, input logic trap);
    int n;
    set_op(ld, st, sz, uns, addr, sd, trap);
    n = 0;
    while (!LS_EX_execute_ready && n < 20) begin
      step;
      n++;
    end
    total++; if (LS_EX_execute_ready !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b exp=1", LS_EX_execute_ready); end
    step;
    EX_LS_reg_execute_valid = 1'b0;
    EX_LS_reg_load = 1'b0;
    EX_LS_reg_store = 1'b0;
  endtask

  task automatic do_mem(input logic [63:0] rdata, input logic err);
    int n;
    n = 0;
    while (!LS_MEM_req_valid && n < 20) begin
      step;
      n++;
    end
    total++; if (LS_MEM_req_valid !== 1'b1) begin bad++; $display("FAIL req_seen got=%b exp=1", LS_MEM_req_valid); end
    MEM_LS_req_ready = 1'b1;
    step;
    MEM_LS_req_ready = 1'b0;
    step;
    step;
    MEM_LS_resp_valid = 1'b1;
    MEM_LS_rdata = rdata;
    MEM_LS_resp_err = err;
    step;
    MEM_LS_resp_valid = 1'b0;
    MEM_LS_resp_err = 1'b0;
    MEM_LS_rdata = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    total++; if (LS_WB_reg_ls_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", LS_WB_reg_ls_valid); end
    total++; if (LS_WB_reg_PC !== RPC) begin bad++; $display("FAIL rst_pc got=%h exp=%h", LS_WB_reg_PC, RPC); end
    total++; if (LS_WB_reg_next_PC !== RPC) begin bad++; $display("FAIL rst_npc got=%h exp=%h", LS_WB_reg_next_PC, RPC); end
    total++; if (LS_WB_reg_data !== 64'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", LS_WB_reg_data); end
    total++; if (LS_MEM_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", LS_MEM_req_valid); end
    total++; if (LS_EX_execute_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", LS_EX_execute_ready); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_ld;
    issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'd0, 1'b0);
    total++; if (LS_MEM_addr !== 64'h8000_0010) begin bad++; $display("FAIL ld_addr got=%h exp=80000010", LS_MEM_addr); end
    total++; if (LS_MEM_wstrb !== 8'hFF) begin bad++; $display("FAIL ld_wstrb got=%h exp=ff", LS_MEM_wstrb); end
    total++; if (LS_MEM_wen !== 1'b0) begin bad++; $display("FAIL ld_wen got=%b exp=0", LS_MEM_wen); end
    do_mem(64'h1122_3344_5566_7788, 1'b0);
    total++; if (LS_WB_reg_ls_valid !== 1'b1) begin bad++; $display("FAIL ld_valid got=%b exp=1", LS_WB_reg_ls_valid); end
    total++; if (LS_WB_reg_data !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL ld_data got=%h exp=1122334455667788", LS_WB_reg_data); end
    total++; if (LS_WB_reg_dest_wen !== 1'b1) begin bad++; $display("FAIL ld_wen_rd got=%b exp=1", LS_WB_reg_dest_wen); end
    total++; if (LS_WB_reg_rd !== 5'd10) begin bad++; $display("FAIL ld_rd got=%0d exp=10", LS_WB_reg_rd); end
    total++; if (LS_WB_reg_PC !== 64'h1000) begin bad++; $display("FAIL ld_pc got=%h exp=1000", LS_WB_reg_PC); end
    step;
    total++; if (LS_WB_reg_ls_valid !== 1'b0) begin bad++; $display("FAIL ld_valid_1cyc got=%b exp=0", LS_WB_reg_ls_valid); end
  endtask

  task automatic test_load_extend;
    issue(1'b1, 1'b0, 2'd0, 1'b0, 64'h8000_0013, 64'd0, 1'b0);
    total++; if (LS_MEM_wstrb !== 8'h08) begin bad++; $display("FAIL lb_wstrb got=%h exp=08", LS_MEM_wstrb); end
    total++; if (LS_MEM_addr !== 64'h8000_0010) begin bad++; $display("FAIL lb_addr got=%h exp=80000010", LS_MEM_addr); end
    do_mem(64'h0000_0000_8000_0000, 1'b0);
    total++; if (LS_WB_reg_data !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffffffffffff80", LS_WB_reg_data); end
    step;
    issue(1'b1, 1'b0, 2'd0, 1'b1, 64'h8000_0013, 64'd0, 1'b0);
    do_mem(64'h0000_0000_8000_0000, 1'b0);
    total++; if (LS_WB_reg_data !== 64'h80) begin bad++; $display("FAIL lbu_data got=%h exp=80", LS_WB_reg_data); end
    step;
    issue(1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0014, 64'd0, 1'b0);
    do_mem(64'h89AB_CDEF_0000_0000, 1'b0);
    total++; if (LS_WB_reg_data !== 64'hFFFF_FFFF_89AB_CDEF) begin bad++; $display("FAIL lw_data got=%h exp=ffffffff89abcdef", LS_WB_reg_data); end
    step;
  endtask

  task automatic test_sh;
    issue(1'b0, 1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 1'b0);
    total++; if (LS_MEM_wstrb !== 8'hC0) begin bad++; $display("FAIL sh_wstrb got=%h exp=c0", LS_MEM_wstrb); end
    total++; if (LS_MEM_wdata[63:48] !== 16'hBEEF) begin bad++; $display("FAIL sh_wdata got=%h exp=beef", LS_MEM_wdata[63:48]); end
    total++; if (LS_MEM_wen !== 1'b1) begin bad++; $display("FAIL sh_wen got=%b exp=1", LS_MEM_wen); end
    total++; if (LS_MEM_addr !== 64'h8000_0000) begin bad++; $display("FAIL sh_addr got=%h exp=80000000", LS_MEM_addr); end
    do_mem(64'd0, 1'b0);
    total++; if (LS_WB_reg_ls_valid !== 1'b1) begin bad++; $display("FAIL sh_valid got=%b exp=1", LS_WB_reg_ls_valid); end
    total++; if (LS_WB_reg_dest_wen !== 1'b0) begin bad++; $display("FAIL sh_dest_wen got=%b exp=0", LS_WB_reg_dest_wen); end
    total++; if (LS_WB_reg_data !== 64'h8000_0006) begin bad++; $display("FAIL sh_data got=%h exp=80000006", LS_WB_reg_data); end
    step;
  endtask

  task automatic test_misaligned;
    issue(1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 1'b0);
    total++; if (LS_MEM_req_valid !== 1'b0) begin bad++; $display("FAIL mis_req got=%b exp=0", LS_MEM_req_valid); end
    total++; if (LS_WB_reg_ls_valid !== 1'b1) begin bad++; $display("FAIL mis_valid got=%b exp=1", LS_WB_reg_ls_valid); end
    total++; if (LS_WB_reg_trap_valid !== 1'b1) begin bad++; $display("FAIL mis_trap got=%b exp=1", LS_WB_reg_trap_valid); end
    total++; if (LS_WB_reg_trap_cause !== 64'd4) begin bad++; $display("FAIL mis_cause got=%0d exp=4", LS_WB_reg_trap_cause); end
    total++; if (LS_WB_reg_trap_tval !== 64'h8000_0002) begin bad++; $display("FAIL mis_tval got=%h exp=80000002", LS_WB_reg_trap_tval); end
    total++; if (LS_WB_reg_dest_wen !== 1'b0) begin bad++; $display("FAIL mis_dest_wen got=%b exp=0", LS_WB_reg_dest_wen); end
    step;
    total++; if (LS_MEM_req_valid !== 1'b0) begin bad++; $display("FAIL mis_req2 got=%b exp=0", LS_MEM_req_valid); end
    issue(1'b0, 1'b1, 2'd3, 1'b0, 64'h8000_0004, 64'd1, 1'b0);
    total++; if (LS_WB_reg_trap_cause !== 64'd6) begin bad++; $display("FAIL mis_st_cause got=%0d exp=6", LS_WB_reg_trap_cause); end
    total++; if (LS_MEM_req_valid !== 1'b0) begin bad++; $display("FAIL mis_st_req got=%b exp=0", LS_MEM_req_valid); end
    step;
  endtask

  task automatic test_faults;
    issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0018, 64'd0, 1'b0);
    do_mem(64'h1234, 1'b1);
    total++; if (LS_WB_reg_trap_valid !== 1'b1) begin bad++; $display("FAIL err_trap got=%b exp=1", LS_WB_reg_trap_valid); end
    total++; if (LS_WB_reg_trap_cause !== 64'd5) begin bad++; $display("FAIL err_cause got=%0d exp=5", LS_WB_reg_trap_cause); end
    total++; if (LS_WB_reg_trap_tval !== 64'h8000_0018) begin bad++; $display("FAIL err_tval got=%h exp=80000018", LS_WB_reg_trap_tval); end
    total++; if (LS_WB_reg_dest_wen !== 1'b0) begin bad++; $display("FAIL err_dest_wen got=%b exp=0", LS_WB_reg_dest_wen); end
    step;
    issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 1'b1);
    total++; if (LS_MEM_req_valid !== 1'b0) begin bad++; $display("FAIL up_req got=%b exp=0", LS_MEM_req_valid); end
    total++; if (LS_WB_reg_trap_cause !== 64'd2) begin bad++; $display("FAIL up_cause got=%0d exp=2", LS_WB_reg_trap_cause); end
    step;
  endtask

  task automatic test_flush;
    issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0020, 64'd0, 1'b0);
    MEM_LS_req_ready = 1'b1;
    step;
    MEM_LS_req_ready = 1'b0;
    WB_LS_flush_flag = 1'b1;
    step;
    WB_LS_flush_flag = 1'b0;
    total++; if (LS_EX_execute_ready !== 1'b0) begin bad++; $display("FAIL fl_drain_ready got=%b exp=0", LS_EX_execute_ready); end
    total++; if (LS_MEM_req_valid !== 1'b0) begin bad++; $display("FAIL fl_req got=%b exp=0", LS_MEM_req_valid); end
    step;
    MEM_LS_resp_valid = 1'b1;
    MEM_LS_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    step;
    MEM_LS_resp_valid = 1'b0;
    total++; if (LS_WB_reg_ls_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", LS_WB_reg_ls_valid); end
    total++; if (LS_EX_execute_ready !== 1'b1) begin bad++; $display("FAIL fl_ready got=%b exp=1", LS_EX_execute_ready); end
    issue(1'b0, 1'b0, 2'd3, 1'b0, 64'h1234, 64'd0, 1'b0);
    total++; if (LS_WB_reg_ls_valid !== 1'b1) begin bad++; $display("FAIL fl_next_valid got=%b exp=1", LS_WB_reg_ls_valid); end
    total++; if (LS_WB_reg_data !== 64'h1234) begin bad++; $display("FAIL fl_next_data got=%h exp=1234", LS_WB_reg_data); end
    step;
  endtask

  task automatic test_back_to_back;
    WB_LS_ls_ready = 1'b0;
    issue(1'b0, 1'b0, 2'd3, 1'b0, 64'hAAAA, 64'd0, 1'b0);
    set_op(1'b0, 1'b0, 2'd3, 1'b0, 64'hBBBB, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++; if (LS_WB_reg_ls_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, LS_WB_reg_ls_valid); end
      total++; if (LS_WB_reg_data !== 64'hAAAA) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=aaaa", i, LS_WB_reg_data); end
      total++; if (LS_EX_execute_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, LS_EX_execute_ready); end
      step;
    end
    WB_LS_ls_ready = 1'b1;
    #1;
    total++; if (LS_EX_execute_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", LS_EX_execute_ready); end
    step;
    EX_LS_reg_execute_valid = 1'b0;
    total++; if (LS_WB_reg_data !== 64'hBBBB) begin bad++; $display("FAIL bp_next_data got=%h exp=bbbb", LS_WB_reg_data); end
    total++; if (LS_WB_reg_ls_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%b exp=1", LS_WB_reg_ls_valid); end
    step;
    total++; if (LS_WB_reg_ls_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", LS_WB_reg_ls_valid); end
  endtask

  task automatic test_reset_mid;
    issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0030, 64'd0, 1'b0);
    total++; if (LS_MEM_req_valid !== 1'b1) begin bad++; $display("FAIL rm_req got=%b exp=1", LS_MEM_req_valid); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    total++; if (LS_MEM_req_valid !== 1'b0) begin bad++; $display("FAIL rm_req_after got=%b exp=0", LS_MEM_req_valid); end
    total++; if (LS_EX_execute_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", LS_EX_execute_ready); end
    total++; if (LS_WB_reg_PC !== RPC) begin bad++; $display("FAIL rm_pc got=%h exp=%h", LS_WB_reg_PC, RPC); end
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_ld;
    test_load_extend;
    test_sh;
    test_misaligned;
    test_faults;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
